timing_gen_mv: RTL
==================

# timing_gen_mv

Parametrised multi-voice timing generator for the synth engine. Sweeps a voice index and an envelope index in nested order, one slot per clock, and emits the combined slot index plus registered frame markers. All outputs are synchronous to the clock's rising edge. Over the previous generator it adds:

- a programmable active-voice count, double-buffered at frame boundaries;
- a pause input;
- separate index fields;
- an optional early-warning pulse.

## Interface

**Parameters**
- VOICES, 8: maximum voice count; must be ≥1.
- V_ENVS, 8: envelopes per voice; must be ≥1.
- V_WIDTH, 3: voice index width; must satisfy 2^V_WIDTH ≥ VOICES.
- E_WIDTH, 3: envelope index width; must satisfy 2^E_WIDTH ≥ V_ENVS.
- PRE_WRAP, 2: lead of pre_wrap before the last slot, in clocks; range 1..VOICES*V_ENVS-1.

**Ports**
- sCLK_XVXENVS, in, 1: clock; all logic on the rising edge.
- reset_reg, in, 1: synchronous, active-high reset.
- run, in, 1: advance enable; low holds every counter and output.
- active_voices, in, V_WIDTH+1: requested voices per frame; sampled only at frame wrap.
- xxxx, out, V_WIDTH+E_WIDTH: combined slot index {vidx, eidx}.
- vidx, out, V_WIDTH: voice index.
- eidx, out, E_WIDTH: envelope index.
- frame_start, out, 1: high in the cycle the slot is (0,0).
- frame_last, out, 1: high in the cycle the slot is the final slot of the frame.
- pre_wrap, out, 1: one-cycle pulse PRE_WRAP advancing clocks before the final slot.
- frame_cnt, out, 16: completed-frame counter.

## Operation

- **Shadow register.** nv_act holds the voice count used by the running frame.
- **Load point.** nv_act loads from active_voices at reset and on every advancing wrap.
- **Clamping.** A value of 0 is treated as 1; a value greater than VOICES is treated as VOICES.
- **Slot sequence.** On each clock with run=1, eidx increments. When eidx = V_ENVS-1, eidx goes to 0 and vidx increments. When vidx = nv_act-1 and eidx = V_ENVS-1, both fields go to 0: this is the wrap.
- **Frame length.** Frame length is L = nv_act*V_ENVS slots.
- **Combined index.** xxxx = {vidx, eidx}. The field layout is fixed. xxxx is a flat count only when V_ENVS = 2^E_WIDTH.
- **Outputs registered.** frame_start, frame_last and pre_wrap are registered. They are computed from the next-state value, so each is valid in the same cycle as the slot it describes.
- **Frame counter.** frame_cnt increments on each advancing wrap and wraps modulo 2^16.
- **Pause.** run=0 freezes all state. The flags keep their current level. pre_wrap is held, not re-pulsed; it re-evaluates on the next advance.
- **active_voices changes mid-frame.** A change takes effect only at the next wrap. The current frame completes with the old nv_act.
- **Single-slot frame.** When L = 1 (nv_act = 1, V_ENVS = 1), frame_start and frame_last are both high every slot.
- **Short frames and pre_wrap.** When PRE_WRAP ≥ L, pre_wrap is suppressed for that frame (held 0).
- **Reset mid-frame.** Reset overrides run. It returns the block to the reset state on the next edge.

## Timing

- **Reset values.** xxxx = 0, vidx = 0, eidx = 0, frame_start = 1, frame_last = (L==1), pre_wrap = 0, frame_cnt = 0. L is computed from the nv_act loaded during reset.
- **First advance.** The first advancing edge after reset release moves to slot (0,1), or to (1,0) when V_ENVS = 1.
- **Index latency.** One clock from an advancing edge to a new index.
- **Flag alignment.** frame_start and frame_last have zero skew relative to xxxx.
- **pre_wrap placement.** pre_wrap is high for the slot whose flat position equals L-1-PRE_WRAP. This is exactly PRE_WRAP advancing clocks before frame_last.
- **Wrap cycle.** After the slot flagged frame_last, the next advancing edge shows slot 0, frame_start = 1 and the incremented frame_cnt, all in the same cycle.

## Configuration

- **Macro.** TIMING_GEN_MV_PREWRAP_EN.
- **Defined.** The pre_wrap comparator and register are built as described above.
- **Undefined.** The pre_wrap port remains but is tied to 0. The PRE_WRAP parameter is ignored. All other behaviour is identical.

## Test plan

- **Reset and free-run.** Defaults, active_voices = 8, run = 1 for 130 clocks. Expect xxxx to sweep 0..63 twice. frame_last at xxxx = 63. frame_start at xxxx = 0. frame_cnt reaches 2.
- **Mid-frame voice change.** Change active_voices 8→3 at slot 20. The current frame still ends at 63. The next frame ends at xxxx = {2,7} = 23, and L = 24 from then on.
- **Clamping.** active_voices = 0 gives L = 8 (vidx stays 0). active_voices = 12 gives L = 64.
- **Pause.** Drop run for 5 clocks at slot 61 with PRE_WRAP = 2. xxxx holds 61 and pre_wrap holds 1 for all 5 clocks. Resume: xxxx goes 62 then 63 (frame_last), with no second pre_wrap pulse.
- **Reset mid-frame.** Assert reset_reg for 1 clock at slot 40 with run = 1. Next cycle: xxxx = 0, frame_start = 1, frame_cnt = 0.
- **Macro off.** Build without TIMING_GEN_MV_PREWRAP_EN and repeat the free-run test. pre_wrap stays 0 throughout; every other output matches the macro-on run exactly.

Source files
------------

// File: rtl/timing_gen_mv.sv
// Multi-voice slot sweeper: {voice, envelope} index with registered frame markers; build with
// TIMING_GEN_MV_PREWRAP_EN to enable the pre_wrap early-warning pulse (otherwise tied low).
module timing_gen_mv #(
    parameter int VOICES   = 8,
    parameter int V_ENVS   = 8,
    parameter int V_WIDTH  = 3,
    parameter int E_WIDTH  = 3,
    parameter int PRE_WRAP = 2
) (
    input  logic                       sCLK_XVXENVS,
    input  logic                       reset_reg,
    input  logic                       run,
    input  logic [V_WIDTH:0]           active_voices,
    output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
    output logic [V_WIDTH-1:0]         vidx,
    output logic [E_WIDTH-1:0]         eidx,
    output logic                       frame_start,
    output logic                       frame_last,
    output logic                       pre_wrap,
    output logic [15:0]                frame_cnt
);

    localparam int NV_W  = V_WIDTH + 1;
    localparam int SLOTS = VOICES * V_ENVS;
    localparam int LW    = $clog2(SLOTS + 1);

    if (VOICES < 1 || V_ENVS < 1 || (1 << V_WIDTH) < VOICES || (1 << E_WIDTH) < V_ENVS
        || PRE_WRAP < 1 || PRE_WRAP >= SLOTS) begin : g_bad_params
        $error("timing_gen_mv: illegal parameter combination");
    end

    function automatic logic [NV_W-1:0] clamp_nv(input logic [NV_W-1:0] av);
        logic [NV_W-1:0] nv;
        nv = av;
        if (av == '0)
            nv = NV_W'(1);
        else if (av > NV_W'(VOICES))
            nv = NV_W'(VOICES);
        return nv;
    endfunction

    function automatic logic [LW-1:0] frame_len(input logic [NV_W-1:0] nv);
        return LW'(nv) * LW'(V_ENVS);
    endfunction

    logic [V_WIDTH-1:0] r_vidx;
    logic [E_WIDTH-1:0] r_eidx;
    logic [NV_W-1:0]    r_nv_act;
    logic [LW-1:0]      r_pos;
    logic               r_frame_start;
    logic               r_frame_last;
    logic [15:0]        r_frame_cnt;

    logic               w_e_last;
    logic               w_wrap;
    logic [V_WIDTH-1:0] w_vidx_nx;
    logic [E_WIDTH-1:0] w_eidx_nx;
    logic [NV_W-1:0]    w_nv_nx;
    logic [LW-1:0]      w_pos_nx;
    logic [LW-1:0]      w_len_nx;
    logic [NV_W-1:0]    w_rst_nv;
    logic [LW-1:0]      w_rst_len;

    assign w_e_last  = (r_eidx == E_WIDTH'(V_ENVS - 1));
    assign w_wrap    = w_e_last && ({1'b0, r_vidx} == (r_nv_act - NV_W'(1)));
    assign w_rst_nv  = clamp_nv(active_voices);
    assign w_rst_len = frame_len(w_rst_nv);

    // Flat position runs alongside the fields so flags work for any V_ENVS, power of two or not.
    always_comb begin
        w_vidx_nx = r_vidx;
        w_eidx_nx = r_eidx + E_WIDTH'(1);
        w_pos_nx  = r_pos + LW'(1);
        w_nv_nx   = r_nv_act;
        if (w_wrap) begin
            w_vidx_nx = '0;
            w_eidx_nx = '0;
            w_pos_nx  = '0;
            w_nv_nx   = clamp_nv(active_voices);
        end else if (w_e_last) begin
            w_eidx_nx = '0;
            w_vidx_nx = r_vidx + V_WIDTH'(1);
        end
    end

    assign w_len_nx = frame_len(w_nv_nx);

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset_reg) begin
            r_vidx        <= '0;
            r_eidx        <= '0;
            r_pos         <= '0;
            r_nv_act      <= w_rst_nv;
            r_frame_start <= 1'b1;
            r_frame_last  <= (w_rst_len == LW'(1));
            r_frame_cnt   <= '0;
        end else if (run) begin
            r_vidx        <= w_vidx_nx;
            r_eidx        <= w_eidx_nx;
            r_pos         <= w_pos_nx;
            r_nv_act      <= w_nv_nx;
            r_frame_start <= (w_pos_nx == '0);
            r_frame_last  <= (w_pos_nx == (w_len_nx - LW'(1)));
            r_frame_cnt   <= r_frame_cnt + {15'd0, w_wrap};
        end
    end

`ifdef TIMING_GEN_MV_PREWRAP_EN
    logic r_pre_wrap;
    logic w_pre_nx;

    // Frames no longer than the lead get no warning at all.
    assign w_pre_nx = (PRE_WRAP < int'(w_len_nx))
                   && (int'(w_pos_nx) == int'(w_len_nx) - 1 - PRE_WRAP);

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset_reg)
            r_pre_wrap <= 1'b0;
        else if (run)
            r_pre_wrap <= w_pre_nx;
    end

    assign pre_wrap = r_pre_wrap;
`else
    assign pre_wrap = 1'b0;
`endif

    assign xxxx        = {r_vidx, r_eidx};
    assign vidx        = r_vidx;
    assign eidx        = r_eidx;
    assign frame_start = r_frame_start;
    assign frame_last  = r_frame_last;
    assign frame_cnt   = r_frame_cnt;

endmodule
